// File: rtl/pipe_pkg.sv
// Shared constants and the occupancy state type for the skid-buffered pipeline stage.
package pipe_pkg;
  localparam int          DATA_W_DEF = 32;
  localparam logic [31:0] NOP_INSTR  = {6'h3F, 26'b0};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;
endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready/data bundle. A beat moves on a rising clock edge when valid & ready are both high;
// once valid is raised, the master holds valid and data stable until ready is seen.
interface pipe_stage_skid_if
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/pipe_sat_counter.sv
// Saturating event counter: counts cycles with i_inc high and sticks at all-ones.
module pipe_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_count = r_count;
endmodule

// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with a 1-entry skid buffer, flush with NOP injection and a registered in_ready.
// Optional statistics counters (stall_cycles, flush_count) are built when PIPE_STAGE_STATS_EN is defined.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int              DATA_W    = DATA_W_DEF,
  parameter logic [DATA_W-1:0] NOP_VALUE = DATA_W'(NOP_INSTR)
`ifdef PIPE_STAGE_STATS_EN
  ,
  parameter int              CNT_W     = 16
`endif
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  pipe_stage_skid_if.slave          in_if,
  pipe_stage_skid_if.master         out_if,
  output occ_state_t                occ_state
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic [CNT_W-1:0]          flush_count
`endif
);
  occ_state_t        r_state;
  occ_state_t        w_state_next;
  logic [DATA_W-1:0] r_main;
  logic [DATA_W-1:0] r_skid;
  logic              w_in_ready;
  logic              w_out_valid;
  logic              w_in_xfer;
  logic              w_out_xfer;
  logic              w_ld_main_in;
  logic              w_ld_main_skid;
  logic              w_ld_skid;

  // in_ready comes straight from the state register, so it never sees out_ready.
  assign w_in_ready  = (r_state != TWO) && !rst;
  assign w_out_valid = (r_state != EMPTY);
  assign w_in_xfer   = in_if.valid && w_in_ready;
  assign w_out_xfer  = w_out_valid && out_if.ready;

  always_comb begin
    w_state_next   = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    case (r_state)
      EMPTY: begin
        if (w_in_xfer) begin
          w_state_next = ONE;
          w_ld_main_in = 1'b1;
        end
      end
      ONE: begin
        if (w_in_xfer && w_out_xfer) begin
          w_ld_main_in = 1'b1;
        end else if (w_in_xfer) begin
          w_state_next = TWO;
          w_ld_skid    = 1'b1;
        end else if (w_out_xfer) begin
          w_state_next = EMPTY;
        end
      end
      TWO: begin
        if (w_out_xfer) begin
          w_state_next   = ONE;
          w_ld_main_skid = 1'b1;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= EMPTY;
      r_main  <= '0;
      r_skid  <= '0;
    end else if (flush) begin
      r_state <= EMPTY;
      r_main  <= NOP_VALUE;
    end else begin
      r_state <= w_state_next;
      if (w_ld_main_in) begin
        r_main <= in_if.data;
      end else if (w_ld_main_skid) begin
        r_main <= r_skid;
      end
      if (w_ld_skid) begin
        r_skid <= in_if.data;
      end
    end
  end

  assign in_if.ready  = w_in_ready;
  assign out_if.valid = w_out_valid;
  assign out_if.data  = r_main;
  assign occ_state    = r_state;

`ifdef PIPE_STAGE_STATS_EN
  pipe_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (w_out_valid && !out_if.ready),
    .o_count (stall_cycles)
  );

  pipe_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_inc   (flush && !rst),
    .o_count (flush_count)
  );
`endif
endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and randomized bench for pipe_stage_skid with an in-order scoreboard.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int          DW  = 32;
  localparam logic [31:0] NOP = 32'hFC00_0000;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic flush = 1'b0;
  occ_state_t occ_state;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DW)) in_if ();
  pipe_stage_skid_if #(.DATA_W(DW)) out_if ();

`ifdef PIPE_STAGE_STATS_EN
  logic [3:0] stall_cycles;
  logic [3:0] flush_count;

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .in_if        (in_if),
    .out_if       (out_if),
    .occ_state    (occ_state),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );
`else
  pipe_stage_skid #(.DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_if     (in_if),
    .out_if    (out_if),
    .occ_state (occ_state)
  );
`endif

  int             total = 0;
  int             bad   = 0;
  int             n_out = 0;
  logic [DW-1:0]  exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input logic iv, input logic [31:0] d, input logic ordy, input logic fl);
    in_if.valid  = iv;
    in_if.data   = d;
    out_if.ready = ordy;
    flush        = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic v, input logic [31:0] d, input logic r);
    check({tag, "_valid"}, 32'(out_if.valid), 32'(v));
    check({tag, "_data"}, out_if.data, d);
    check({tag, "_in_ready"}, 32'(in_if.ready), 32'(r));
  endtask

  // Scoreboard: deliveries are popped before the flush/accept of the same edge is applied.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_if.valid && out_if.ready) begin
        n_out++;
        check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("sb_data", out_if.data, exp_q.pop_front());
      end
      if (flush) exp_q.delete();
      else if (in_if.valid && in_if.ready) exp_q.push_back(in_if.data);
    end
  end

  initial begin
    logic [31:0] d;
    logic        iv;
    logic        ordy;
    logic        acc;
    logic        hold;
    logic [31:0] pd;
    int          n0;
    int          miss;

    in_if.valid  = 1'b0;
    in_if.data   = '0;
    out_if.ready = 1'b0;
    #1;
    check("rst_in_ready_low", 32'(in_if.ready), 32'd0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    check("rst_hold_in_ready_low", 32'(in_if.ready), 32'd0);
    rst = 1'b0;
    step(0, 0, 0, 0);
    expect_out("reset", 1'b0, 32'h0, 1'b1);
    check("reset_state", 32'(occ_state), 32'(EMPTY));

    // Full-rate stream.
    for (int i = 1; i <= 8; i++) begin
      step(1, 32'(i), 1, 0);
      expect_out("t1_beat", 1'b1, 32'(i), 1'b1);
    end
    step(0, 0, 1, 0);
    expect_out("t1_idle", 1'b0, 32'h8, 1'b1);

    // Downstream stall for three cycles mid-stream.
    step(1, 32'hA0, 1, 0);
    expect_out("t2_a0", 1'b1, 32'hA0, 1'b1);
    step(1, 32'hA1, 0, 0);
    expect_out("t2_stall1", 1'b1, 32'hA0, 1'b0);
    check("t2_state_two", 32'(occ_state), 32'(TWO));
    step(1, 32'hA2, 0, 0);
    expect_out("t2_stall2", 1'b1, 32'hA0, 1'b0);
    step(1, 32'hA2, 0, 0);
    expect_out("t2_stall3", 1'b1, 32'hA0, 1'b0);
    step(1, 32'hA2, 1, 0);
    expect_out("t2_drain_skid", 1'b1, 32'hA1, 1'b1);
    step(1, 32'hA2, 1, 0);
    expect_out("t2_a2", 1'b1, 32'hA2, 1'b1);
    step(1, 32'hA3, 1, 0);
    expect_out("t2_a3", 1'b1, 32'hA3, 1'b1);
    step(0, 0, 1, 0);
    expect_out("t2_idle", 1'b0, 32'hA3, 1'b1);
    check("t2_q_empty", 32'(exp_q.size()), 32'd0);

    // Flush from TWO with a beat offered in the flush cycle.
    step(1, 32'hB0, 0, 0);
    expect_out("t3_b0", 1'b1, 32'hB0, 1'b1);
    step(1, 32'hB1, 0, 0);
    expect_out("t3_two", 1'b1, 32'hB0, 1'b0);
    step(1, 32'hB2, 0, 1);
    expect_out("t3_flush", 1'b0, NOP, 1'b1);
    check("t3_state_empty", 32'(occ_state), 32'(EMPTY));
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      expect_out("t3_after", 1'b0, NOP, 1'b1);
    end
    step(1, 32'hD0, 1, 0);
    expect_out("t3_d0", 1'b1, 32'hD0, 1'b1);
    step(1, 32'hD1, 1, 1);
    expect_out("t3_flush_one", 1'b0, NOP, 1'b1);
    step(1, 32'hC0, 1, 0);
    expect_out("t3_c0", 1'b1, 32'hC0, 1'b1);
    step(0, 0, 1, 0);
    expect_out("t3_idle", 1'b0, 32'hC0, 1'b1);
    check("t3_q_empty", 32'(exp_q.size()), 32'd0);

    // Reset and flush together: reset wins.
    step(1, 32'hE0, 0, 0);
    expect_out("t4_e0", 1'b1, 32'hE0, 1'b1);
    rst = 1'b1;
    step(0, 0, 0, 1);
    expect_out("t4_rst_flush", 1'b0, 32'h0, 1'b0);
    rst = 1'b0;
    step(0, 0, 1, 0);
    expect_out("t4_after", 1'b0, 32'h0, 1'b1);

    // Random valid/ready with hold-stability checks.
    d = 32'h1000;
    for (int i = 0; i < 2000; i++) begin
      iv   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      in_if.valid  = iv;
      in_if.data   = d;
      out_if.ready = ordy;
      flush        = 1'b0;
      #1;
      acc  = iv && in_if.ready;
      hold = out_if.valid && !ordy;
      pd   = out_if.data;
      @(posedge clk);
      #1;
      if (acc) d = d + 1;
      if (hold) begin
        check("t5_hold_valid", 32'(out_if.valid), 32'd1);
        check("t5_hold_data", out_if.data, pd);
      end
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    check("t5_q_empty", 32'(exp_q.size()), 32'd0);

    // Throughput at 100% duty.
    n0   = n_out;
    miss = 0;
    for (int i = 0; i < 50; i++) begin
      if (in_if.ready !== 1'b1) miss++;
      step(1, d, 1, 0);
      d = d + 1;
    end
    step(0, 0, 1, 0);
    check("t5_full_rate_ready", 32'(miss), 32'd0);
    check("t5_full_rate_out", 32'(n_out - n0), 32'd50);
    check("t5_q_drained", 32'(exp_q.size()), 32'd0);

`ifdef PIPE_STAGE_STATS_EN
    rst = 1'b1;
    step(0, 0, 0, 0);
    rst = 1'b0;
    check("t6_stall_reset", 32'(stall_cycles), 32'd0);
    step(1, 32'hF0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check("t6_stall_3", 32'(stall_cycles), 32'd3);
    for (int i = 0; i < 17; i++) step(0, 0, 0, 0);
    check("t6_stall_sat", 32'(stall_cycles), 32'd15);
    check("t6_flush_zero", 32'(flush_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
    check("t6_flush_count", 32'(flush_count), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
